// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and window-bound helpers, shared by timing and pixel logic.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package vga_pkg;
    localparam int CNT_W = 10;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;

    // Visible window runs from sync+back-porch up to, and including, that plus active-1.
    function automatic logic [CNT_W-1:0] win_first(input int sync, input int bp);
        return CNT_W'(sync + bp);
    endfunction

    function automatic logic [CNT_W-1:0] win_last(input int sync, input int bp, input int act);
        return CNT_W'(sync + bp + act - 1);
    endfunction
endpackage

// File: rtl/vga_counter.sv
// Wrap counter with enable; wrap pulse is high on the enabled cycle that returns to zero.
// Latency: count updates one clk after en; wrap is combinational from count and en.
// Backpressure: none, advances whenever en is high.
module vga_counter #(
    parameter int W     = 10,
    parameter int TOTAL = 800
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // >= rather than == so an out-of-range value can never run past TOTAL-1.
    assign wrap = en && (count >= LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en) begin
            count <= (count >= LAST) ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-rate enable, h/v counters, syncs, visible window, frame start.
// Latency: decoded outputs are combinational from the counter registers (zero cycle).
// Backpressure: none, free-running at clk/2 pixel rate.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             bright,
    output logic             frame_start
);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_FIRST    = win_first(H_SYNC, H_BP);
    localparam logic [CNT_W-1:0] H_LAST     = win_last(H_SYNC, H_BP, H_ACTIVE);
    localparam logic [CNT_W-1:0] V_FIRST    = win_first(V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] V_LAST     = win_last(V_SYNC, V_BP, V_ACTIVE);

    logic tick;
    logic h_wrap;
    logic v_wrap_unused;
    logic h_act;
    logic v_act;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick <= 1'b0;
        end else begin
            tick <= ~tick;
        end
    end

    vga_counter #(.W(CNT_W), .TOTAL(H_TOTAL)) u_hcnt (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (tick),
        .count (hcount),
        .wrap  (h_wrap)
    );

    // Vertical advances only on the pixel slot where the line wraps.
    vga_counter #(.W(CNT_W), .TOTAL(V_TOTAL)) u_vcnt (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (h_wrap),
        .count (vcount),
        .wrap  (v_wrap_unused)
    );

    assign pix_en      = tick;
    assign hsync       = (hcount >= H_SYNC_END);
    assign vsync       = (vcount >= V_SYNC_END);
    assign h_act       = (hcount >= H_FIRST) && (hcount <= H_LAST);
    assign v_act       = (vcount >= V_FIRST) && (vcount <= V_LAST);
    assign bright      = h_act && v_act;
    assign frame_start = tick && (hcount == '0) && (vcount == '0);
endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size instance for line timing/reset, small-geometry instance for whole-frame behaviour.
module tb_vga_timing;
    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       pix_en, hsync, vsync, bright, frame_start;
    logic [9:0] hcount, vcount;
    logic       s_pix_en, s_hsync, s_vsync, s_bright, s_frame_start;
    logic [9:0] s_hcount, s_vcount;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    vga_timing dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .pix_en      (pix_en),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .bright      (bright),
        .frame_start (frame_start)
    );

    // 16 pixels/line (sync 4, bp 2, active 8, fp 2); 8 lines/frame (sync 2, bp 1, active 3, fp 2).
    vga_timing #(
        .H_SYNC(4), .H_BP(2), .H_ACTIVE(8), .H_TOTAL(16),
        .V_SYNC(2), .V_BP(1), .V_ACTIVE(3), .V_TOTAL(8)
    ) dut_s (
        .clk         (clk),
        .clr_n       (clr_n),
        .pix_en      (s_pix_en),
        .hcount      (s_hcount),
        .vcount      (s_vcount),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .bright      (s_bright),
        .frame_start (s_frame_start)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with clr_n just released (sample index k=0).
    task automatic restart();
        @(negedge clk);
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({pix_en, hsync, vsync, bright, frame_start} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000", {pix_en, hsync, vsync, bright, frame_start});
        end
        n_cmp++;
        if (hcount !== 10'd0 || vcount !== 10'd0) begin
            n_err++;
            $display("FAIL reset_counts: got h=%0d v=%0d want 0 0", hcount, vcount);
        end
        n_cmp++;
        if ({s_pix_en, s_hsync, s_vsync, s_bright, s_frame_start} !== 5'b0 || s_hcount !== 10'd0 || s_vcount !== 10'd0) begin
            n_err++;
            $display("FAIL reset_small: got flags=%b h=%0d v=%0d want 0", {s_pix_en, s_hsync, s_vsync, s_bright, s_frame_start}, s_hcount, s_vcount);
        end
    endtask

    task automatic test_first_edges();
        restart();
        step();
        n_cmp++;
        if (pix_en !== 1'b1 || hcount !== 10'd0 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL first_edge: got pix_en=%b h=%0d fs=%b want 1 0 1", pix_en, hcount, frame_start);
        end
        step();
        n_cmp++;
        if (pix_en !== 1'b0 || hcount !== 10'd1 || frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL second_edge: got pix_en=%b h=%0d fs=%b want 0 1 0", pix_en, hcount, frame_start);
        end
    endtask

    task automatic test_line();
        int errs = 0, pulses = 0, hs_low = 0, first_k = -1;
        logic [9:0] first_hi_h = 10'h3ff;
        logic [9:0] eh, ev;
        logic       ep;
        restart();
        for (int k = 1; k <= 1600; k++) begin
            step();
            eh = 10'((k / 2) % 800);
            ev = 10'((k / 2) / 800);
            ep = (k % 2) == 1;
            if (pix_en !== ep || hcount !== eh || vcount !== ev || bright !== 1'b0) begin
                if (first_k < 0) first_k = k;
                errs++;
            end
            if (pix_en === 1'b1) begin
                pulses++;
                if (hsync === 1'b0) hs_low++;
                if (hsync === 1'b1 && first_hi_h == 10'h3ff) first_hi_h = hcount;
            end
        end
        n_cmp++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL line_seq: got %0d bad samples (first at clk %0d) want 0", errs, first_k);
        end
        n_cmp++;
        if (pulses != 800) begin
            n_err++;
            $display("FAIL pix_en_count: got %0d want 800", pulses);
        end
        n_cmp++;
        if (hcount !== 10'd0 || vcount !== 10'd1) begin
            n_err++;
            $display("FAIL line_wrap: got h=%0d v=%0d want 0 1", hcount, vcount);
        end
        n_cmp++;
        if (hs_low != 96) begin
            n_err++;
            $display("FAIL hsync_width: got %0d slots want 96", hs_low);
        end
        n_cmp++;
        if (first_hi_h !== 10'd96) begin
            n_err++;
            $display("FAIL hsync_rise: got hcount %0d want 96", first_hi_h);
        end
    endtask

    task automatic test_frame_small();
        int errs = 0, first_k = -1, br = 0, vs_low = 0, fs = 0;
        int fs_k0 = -1, fs_k1 = -1;
        int p;
        logic [9:0] h, v;
        logic [9:0] fb_h = 10'h3ff, fb_v = 10'h3ff, lb_h = 10'h3ff, lb_v = 10'h3ff;
        logic tk, ehs, evs, ebr, efs;
        restart();
        for (int k = 1; k <= 512; k++) begin
            step();
            p   = k / 2;
            h   = 10'(p % 16);
            v   = 10'((p / 16) % 8);
            tk  = (k % 2) == 1;
            ehs = h >= 10'd4;
            evs = v >= 10'd2;
            ebr = (h >= 10'd6) && (h <= 10'd13) && (v >= 10'd3) && (v <= 10'd5);
            efs = tk && h == 10'd0 && v == 10'd0;
            if (s_pix_en !== tk || s_hcount !== h || s_vcount !== v || s_hsync !== ehs ||
                s_vsync !== evs || s_bright !== ebr || s_frame_start !== efs) begin
                if (first_k < 0) first_k = k;
                errs++;
            end
            if (s_pix_en === 1'b1 && k <= 256) begin
                if (s_bright === 1'b1) begin
                    br++;
                    if (fb_h == 10'h3ff) begin fb_h = s_hcount; fb_v = s_vcount; end
                    lb_h = s_hcount;
                    lb_v = s_vcount;
                end
                if (s_vsync === 1'b0) vs_low++;
            end
            if (s_frame_start === 1'b1) begin
                fs++;
                if (fs_k0 < 0) fs_k0 = k; else if (fs_k1 < 0) fs_k1 = k;
            end
        end
        n_cmp++;
        if (errs != 0) begin
            n_err++;
            $display("FAIL frame_seq: got %0d bad samples (first at clk %0d) want 0", errs, first_k);
        end
        n_cmp++;
        if (br != 24) begin
            n_err++;
            $display("FAIL bright_count: got %0d want 24", br);
        end
        n_cmp++;
        if (fb_h !== 10'd6 || fb_v !== 10'd3 || lb_h !== 10'd13 || lb_v !== 10'd5) begin
            n_err++;
            $display("FAIL bright_window: got first %0d,%0d last %0d,%0d want 6,3 13,5", fb_h, fb_v, lb_h, lb_v);
        end
        n_cmp++;
        if (vs_low != 32) begin
            n_err++;
            $display("FAIL vsync_width: got %0d slots want 32", vs_low);
        end
        n_cmp++;
        if (fs != 2 || fs_k1 - fs_k0 != 256) begin
            n_err++;
            $display("FAIL frame_start_period: got %0d pulses spacing %0d clk want 2 and 256", fs, fs_k1 - fs_k0);
        end
    endtask

    task automatic test_double_wrap();
        restart();
        repeat (255) step();
        n_cmp++;
        if (s_hcount !== 10'd15 || s_vcount !== 10'd7 || s_pix_en !== 1'b1) begin
            n_err++;
            $display("FAIL pre_wrap: got h=%0d v=%0d pix_en=%b want 15 7 1", s_hcount, s_vcount, s_pix_en);
        end
        step();
        n_cmp++;
        if (s_hcount !== 10'd0 || s_vcount !== 10'd0 || s_frame_start !== 1'b0) begin
            n_err++;
            $display("FAIL double_wrap: got h=%0d v=%0d fs=%b want 0 0 0", s_hcount, s_vcount, s_frame_start);
        end
        step();
        n_cmp++;
        if (s_frame_start !== 1'b1 || s_pix_en !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_frame_start: got fs=%b pix_en=%b want 1 1", s_frame_start, s_pix_en);
        end
    endtask

    task automatic test_async_reset();
        restart();
        repeat (1001) step();
        n_cmp++;
        if (hcount !== 10'd500 || pix_en !== 1'b1 || hsync !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_main: got h=%0d pix_en=%b hsync=%b want 500 1 1", hcount, pix_en, hsync);
        end
        #3 clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({pix_en, hsync, vsync, bright, frame_start} !== 5'b0 || hcount !== 10'd0 || vcount !== 10'd0) begin
            n_err++;
            $display("FAIL async_reset_main: got flags=%b h=%0d v=%0d want 0", {pix_en, hsync, vsync, bright, frame_start}, hcount, vcount);
        end
        restart();
        repeat (149) step();
        n_cmp++;
        if (s_bright !== 1'b1 || s_vsync !== 1'b1 || s_hcount !== 10'd10 || s_vcount !== 10'd4) begin
            n_err++;
            $display("FAIL pre_reset_small: got bright=%b vsync=%b h=%0d v=%0d want 1 1 10 4", s_bright, s_vsync, s_hcount, s_vcount);
        end
        #3 clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_pix_en, s_hsync, s_vsync, s_bright, s_frame_start} !== 5'b0 || s_hcount !== 10'd0 || s_vcount !== 10'd0) begin
            n_err++;
            $display("FAIL async_reset_small: got flags=%b h=%0d v=%0d want 0", {s_pix_en, s_hsync, s_vsync, s_bright, s_frame_start}, s_hcount, s_vcount);
        end
        @(negedge clk);
        clr_n = 1'b1;
        step();
        n_cmp++;
        if (hcount !== 10'd0 || vcount !== 10'd0 || pix_en !== 1'b1) begin
            n_err++;
            $display("FAIL resume_edge1: got h=%0d v=%0d pix_en=%b want 0 0 1", hcount, vcount, pix_en);
        end
        step();
        n_cmp++;
        if (hcount !== 10'd1 || s_hcount !== 10'd1 || pix_en !== 1'b0) begin
            n_err++;
            $display("FAIL resume_edge2: got h=%0d small h=%0d pix_en=%b want 1 1 0", hcount, s_hcount, pix_en);
        end
    endtask

    initial begin
        test_reset();
        test_first_edges();
        test_line();
        test_frame_small();
        test_double_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
